// File: rtl/tt_sweep_ctrl_pkg.sv
// Shared definitions for the truth-table sweep sequencer:
// FSM state encodings and table geometry.
package tt_sweep_ctrl_pkg;

    localparam int N_VEC = 16;
    localparam int TBL_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/tt_sweep_cnt.sv
// Vector index and settle-time counters for the sweep engine.
// Raises the sample strobe on the last hold cycle of each vector.
module tt_sweep_cnt
    import tt_sweep_ctrl_pkg::*;
#(
    parameter int HOLD_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       enable,
    output logic [3:0] idx,
    output logic       sample,
    output logic       last_vec
);

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);
    localparam logic [3:0] IDX_LAST  = 4'(N_VEC - 1);

    logic [3:0] hold_cnt;

    assign sample   = enable && (hold_cnt == HOLD_LAST);
    assign last_vec = (idx == IDX_LAST);

    // idx stops at the last vector; the FSM leaves APPLY on that strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            hold_cnt <= '0;
        end else if (clear) begin
            idx      <= '0;
            hold_cnt <= '0;
        end else if (enable) begin
            if (sample) begin
                hold_cnt <= '0;
                if (!last_vec) begin
                    idx <= idx + 4'd1;
                end
            end else begin
                hold_cnt <= hold_cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Self-test sequencer: sweeps all 16 input vectors of a 4-in/2-out gate
// network, captures f/g per vector and compares against a golden table.
module tt_sweep_ctrl
    import tt_sweep_ctrl_pkg::*;
#(
    parameter int HOLD_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [TBL_W-1:0] exp_table,
    input  logic             f_in,
    input  logic             g_in,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    output logic             busy,
    output logic             done,
    output logic [TBL_W-1:0] result,
    output logic [4:0]       err_cnt,
    output logic [3:0]       first_err,
    output logic             pass
);

    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_hold
        $error("tt_sweep_ctrl: HOLD_CYCLES must be within 1..15");
    end

    state_t     state;
    state_t     state_next;
    logic       start_ok;
    logic       cnt_clear;
    logic       cnt_enable;
    logic [3:0] idx;
    logic       sample;
    logic       last_vec;
    logic [1:0] exp_pair;
    logic       mismatch;
    logic [4:0] err_next;

    tt_sweep_cnt #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (cnt_clear),
        .enable  (cnt_enable),
        .idx     (idx),
        .sample  (sample),
        .last_vec(last_vec)
    );

    // The counter register drives the network directly; it is zero whenever idle
    assign {a, b, c, d} = idx;

    assign start_ok   = (state == ST_IDLE) && start;
    assign cnt_clear  = start_ok || (state == ST_DONE);
    assign cnt_enable = (state == ST_APPLY);

    assign exp_pair = exp_table[2*idx +: 2];
    assign mismatch = ({f_in, g_in} != exp_pair);
    assign err_next = err_cnt + {4'd0, mismatch};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = ST_APPLY;
            ST_APPLY: if (sample && last_vec) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // pass is settled on the same edge as the final capture so it is valid with done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            err_cnt   <= '0;
            first_err <= '0;
            pass      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start_ok) begin
                busy      <= 1'b1;
                result    <= '0;
                err_cnt   <= '0;
                first_err <= '0;
                pass      <= 1'b0;
            end else if (sample) begin
                result[2*idx +: 2] <= {f_in, g_in};
                if (mismatch) begin
                    err_cnt <= err_next;
                    if (err_cnt == 5'd0) begin
                        first_err <= idx;
                    end
                end
                if (last_vec) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    pass <= (err_next == 5'd0);
                end
            end
        end
    end

endmodule
